int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 137 +++++++++++++
 tb/tb_int_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// 4-line fixed-priority vectored interrupt controller (line 0 highest priority).
// Define INT_CTRL_NEST_EN to let a higher-priority line preempt the service in progress.
module int_ctrl #(
   parameter logic [9:0] VEC1 = 10'b1111111011,
   parameter logic [9:0] VEC2 = 10'b1111111110,
   parameter logic [9:0] VEC3 = 10'b1111111101,
   parameter logic [9:0] VEC4 = 10'b1111111100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] irq_in,
   input  logic       mask_we,
   input  logic [3:0] mask_d,
   input  logic       ack,
   input  logic       reti,
   output logic       irq,
   output logic [9:0] vector,
   output logic [3:0] mask_q,
   output logic [3:0] pending,
   output logic [3:0] in_service
);

   typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

   state_t      state_q, state_d;
   logic [3:0]  prev_q, prev_d;
   logic [1:0]  sel_q, sel_d;
   logic        irq_q, irq_d;
   logic [9:0]  vector_q, vector_d;
   logic [3:0]  pending_q, pending_d;
   logic [3:0]  in_service_q, in_service_d;

   logic [3:0]  rise;
   logic [3:0]  eligible;
   logic [3:0]  pending_clr;
   logic [3:0]  top_service;
   logic [3:0]  above_top;

   function automatic logic [1:0] highest(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   function automatic logic [9:0] vec_of(input logic [1:0] s);
      case (s)
         2'd0:    return VEC1;
         2'd1:    return VEC2;
         2'd2:    return VEC3;
         default: return VEC4;
      endcase
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      sel_d        = sel_q;
      irq_d        = irq_q;
      vector_d     = vector_q;
      in_service_d = in_service_q;
      pending_clr  = 4'b0000;
      prev_d       = irq_in;

      rise     = irq_in & ~prev_q;
      eligible = pending_q & mask_q;
      // Lowest set in_service bit is the level being served; lines below its index outrank it.
      top_service = in_service_q & (~in_service_q + 4'd1);
      above_top   = top_service - 4'd1;

      case (state_q)
         IDLE: begin
            if (eligible != 4'b0000 && in_service_q == 4'b0000) begin
               sel_d    = highest(eligible);
               vector_d = vec_of(highest(eligible));
               irq_d    = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (ack) begin
               pending_clr               = 4'b0001 << sel_q;
               in_service_d              = in_service_q | (4'b0001 << sel_q);
               irq_d                     = 1'b0;
               state_d                   = SVC;
            end
         end
         SVC: begin
            if (reti) begin
               in_service_d = in_service_q & ~top_service;
               if ((in_service_q & ~top_service) == 4'b0000) state_d = IDLE;
            end
`ifdef INT_CTRL_NEST_EN
            else if ((eligible & above_top) != 4'b0000) begin
               sel_d    = highest(eligible);
               vector_d = vec_of(highest(eligible));
               irq_d    = 1'b1;
               state_d  = REQ;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      // A new edge in the ack cycle wins over the clear.
      pending_d = (pending_q & ~pending_clr) | rise;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         prev_q       <= 4'b0000;
         sel_q        <= 2'd0;
         irq_q        <= 1'b0;
         vector_q     <= 10'd0;
         mask_q       <= 4'b0000;
         pending_q    <= 4'b0000;
         in_service_q <= 4'b0000;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         sel_q        <= sel_d;
         irq_q        <= irq_d;
         vector_q     <= vector_d;
         if (mask_we) mask_q <= mask_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
      end
   end

   assign irq        = irq_q;
   assign vector     = vector_q;
   assign pending    = pending_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: each expected interrupt (vector, cycle) is queued by the
// stimulus and popped by a monitor whenever irq rises; status registers are checked directly.
module tb_int_ctrl;

   localparam logic [9:0] V1 = 10'b1111111011;
   localparam logic [9:0] V2 = 10'b1111111110;
   localparam logic [9:0] V3 = 10'b1111111101;
   localparam logic [9:0] V4 = 10'b1111111100;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq_in;
   logic       mask_we;
   logic [3:0] mask_d;
   logic       ack;
   logic       reti;
   logic       irq;
   logic [9:0] vector;
   logic [3:0] mask_q;
   logic [3:0] pending;
   logic [3:0] in_service;

   int_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_d     (mask_d),
      .ack        (ack),
      .reti       (reti),
      .irq        (irq),
      .vector     (vector),
      .mask_q     (mask_q),
      .pending    (pending),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [9:0] vec;
      int         at;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic irq_was = 1'b0;

   // Monitor: every rising irq must match the oldest queued expectation.
   always @(negedge clk) begin
      if (irq === 1'b1 && irq_was !== 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_irq vector=%b cycle=%0d", vector, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (vector !== e.vec || cyc != e.at) begin
               errors++;
               $display("FAIL irq_vector got vector=%b cycle=%0d want vector=%b cycle=%0d",
                        vector, cyc, e.vec, e.at);
            end
         end
      end
      irq_was = irq;
   end

   task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b", name, got, want);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_irq(input logic [9:0] v, input int at);
      exp_t e;
      e.vec = v;
      e.at  = at;
      exp_q.push_back(e);
   endtask

   task automatic pulse(input logic [3:0] lines);
      irq_in = lines;
      tick();
      irq_in = 4'b0000;
   endtask

   task automatic set_mask(input logic [3:0] m);
      mask_d  = m;
      mask_we = 1'b1;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic do_reti();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic wait_irq();
      int n = 0;
      while (irq !== 1'b1 && n < 16) begin
         tick();
         n++;
      end
      if (irq !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_irq timeout got irq=%b want irq=1", irq);
      end
   endtask

   initial begin
      reset = 1'b1; irq_in = 4'b0000; mask_we = 1'b0; mask_d = 4'b0000;
      ack = 1'b0; reti = 1'b0;
      tick(2);
      check("rst_irq", {9'd0, irq}, 10'd0);
      check("rst_vector", vector, 10'd0);
      check("rst_mask", {6'd0, mask_q}, 10'd0);
      check("rst_pending", {6'd0, pending}, 10'd0);
      check("rst_in_service", {6'd0, in_service}, 10'd0);
      reset = 1'b0;

      // Single request on line 2, two-cycle latency.
      set_mask(4'b1111);
      check("mask_load", {6'd0, mask_q}, 10'b1111);
      expect_irq(V3, cyc + 2);
      pulse(4'b0100);
      check("l2_pending", {6'd0, pending}, 10'b0100);
      check("l2_irq_not_yet", {9'd0, irq}, 10'd0);
      wait_irq();
      do_ack();
      check("l2_ack_pending", {6'd0, pending}, 10'd0);
      check("l2_ack_in_service", {6'd0, in_service}, 10'b0100);
      check("l2_ack_irq", {9'd0, irq}, 10'd0);
      do_reti();
      check("l2_reti", {6'd0, in_service}, 10'd0);

      // Lines 0 and 3 together: line 0 first, line 3 after reti.
      expect_irq(V1, cyc + 2);
      pulse(4'b1001);
      wait_irq();
      do_ack();
      check("pri_in_service", {6'd0, in_service}, 10'b0001);
      check("pri_pending", {6'd0, pending}, 10'b1000);
      tick(2);
      expect_irq(V4, cyc + 2);
      do_reti();
      wait_irq();
      do_ack();
      do_reti();
      check("pri_done", {6'd0, in_service}, 10'd0);

      // Masked request waits, then fires two cycles after the mask write.
      set_mask(4'b0000);
      pulse(4'b0010);
      tick(2);
      check("masked_pending", {6'd0, pending}, 10'b0010);
      check("masked_irq", {9'd0, irq}, 10'd0);
      expect_irq(V2, cyc + 2);
      set_mask(4'b0010);
      wait_irq();
      do_ack();
      do_reti();
      set_mask(4'b1111);

      // Line 0 arrives while line 3 is in service.
      expect_irq(V4, cyc + 2);
      pulse(4'b1000);
      wait_irq();
      do_ack();
`ifdef INT_CTRL_NEST_EN
      expect_irq(V1, cyc + 2);
      pulse(4'b0001);
      wait_irq();
      do_ack();
      check("nest_in_service", {6'd0, in_service}, 10'b1001);
      do_reti();
      check("nest_reti1", {6'd0, in_service}, 10'b1000);
      do_reti();
      check("nest_reti2", {6'd0, in_service}, 10'd0);
`else
      pulse(4'b0001);
      tick(3);
      check("nonest_irq", {9'd0, irq}, 10'd0);
      check("nonest_pending", {6'd0, pending}, 10'b0001);
      expect_irq(V1, cyc + 2);
      do_reti();
      wait_irq();
      do_ack();
      do_reti();
      check("nonest_done", {6'd0, in_service}, 10'd0);
`endif

      // New edge on line 1 during its own ack keeps it pending.
      expect_irq(V2, cyc + 2);
      pulse(4'b0010);
      wait_irq();
      irq_in = 4'b0010;
      ack    = 1'b1;
      tick();
      irq_in = 4'b0000;
      ack    = 1'b0;
      check("ackedge_pending", {6'd0, pending}, 10'b0010);
      check("ackedge_in_service", {6'd0, in_service}, 10'b0010);
      expect_irq(V2, cyc + 2);
      do_reti();
      wait_irq();
      do_ack();
      check("ackedge_cleared", {6'd0, pending}, 10'd0);
      do_reti();

      // Mask cleared while requesting: no withdrawal.
      expect_irq(V3, cyc + 2);
      pulse(4'b0100);
      wait_irq();
      set_mask(4'b0000);
      tick(2);
      check("nowd_irq", {9'd0, irq}, 10'd1);
      check("nowd_vector", vector, V3);
      do_ack();
      check("nowd_in_service", {6'd0, in_service}, 10'b0100);
      do_reti();
      set_mask(4'b1111);

      // Stray ack/reti in IDLE are ignored.
      do_ack();
      check("stray_ack_in_service", {6'd0, in_service}, 10'd0);
      check("stray_ack_irq", {9'd0, irq}, 10'd0);
      do_reti();
      check("stray_reti_in_service", {6'd0, in_service}, 10'd0);

      // Reset in REQ abandons the transaction.
      expect_irq(V3, cyc + 2);
      pulse(4'b0100);
      wait_irq();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstreq_irq", {9'd0, irq}, 10'd0);
      check("rstreq_pending", {6'd0, pending}, 10'd0);
      check("rstreq_mask", {6'd0, mask_q}, 10'd0);
      check("rstreq_vector", vector, 10'd0);
      do_ack();
      check("rstreq_ack_in_service", {6'd0, in_service}, 10'd0);
      check("rstreq_ack_irq", {9'd0, irq}, 10'd0);

      // Line held high across reset release is captured once.
      irq_in = 4'b0001;
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
      check("held_rst_pending", {6'd0, pending}, 10'd0);
      tick();
      check("held_pending", {6'd0, pending}, 10'b0001);
      tick(2);
      expect_irq(V1, cyc + 2);
      set_mask(4'b0001);
      wait_irq();
      do_ack();
      check("held_ack_pending", {6'd0, pending}, 10'd0);
      tick(2);
      check("held_no_repeat", {6'd0, pending}, 10'd0);
      do_reti();
      irq_in = 4'b0000;
      tick(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_irq got outstanding=%0d want outstanding=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
